// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types and constants for the RC4 schedule/keystream generator.
//   rc4_state_t          - controller state encoding
//   MODE_*               - run-mode encodings (mode 3 is folded onto MODE_KSA)
//   KSA_CYCLES_PER_ITER  - clock cycles per KSA swap iteration when the RAM acks
//                          one cycle after mem_req rises (4 per memory op x 4 ops,
//                          plus KSA_CALC and KSA_NEXT)
//   is_mem_state()       - true for states that perform exactly one RAM access
package rc4_pkg;

    typedef enum logic [4:0] {
        ST_IDLE,
        ST_KSA_RD_I,
        ST_KSA_CALC,
        ST_KSA_RD_J,
        ST_KSA_WR_I,
        ST_KSA_WR_J,
        ST_KSA_NEXT,
        ST_PRGA_INIT,
        ST_PRGA_INC,
        ST_PRGA_RD_I,
        ST_PRGA_CALC,
        ST_PRGA_RD_J,
        ST_PRGA_WR_I,
        ST_PRGA_WR_J,
        ST_PRGA_RD_T,
        ST_PRGA_OUT,
        ST_DONE
    } rc4_state_t;

    localparam logic [1:0] MODE_KSA  = 2'd0;
    localparam logic [1:0] MODE_PRGA = 2'd1;
    localparam logic [1:0] MODE_BOTH = 2'd2;

    localparam int KSA_CYCLES_PER_ITER = 18;

    function automatic logic is_mem_state(input rc4_state_t s);
        return s inside {ST_KSA_RD_I, ST_KSA_RD_J, ST_KSA_WR_I, ST_KSA_WR_J,
                         ST_PRGA_RD_I, ST_PRGA_RD_J, ST_PRGA_WR_I, ST_PRGA_WR_J,
                         ST_PRGA_RD_T};
    endfunction

endpackage

// File: rtl/rc4_mem_port.sv
// rc4_mem_port: req/ack sequencer for the shared single-port S RAM.
//   i_op/i_addr/i_wdata/i_we : one-cycle op pulse from the controller
//   o_rdone/o_rdata          : one-cycle completion pulse, read data captured at ack
//   o_mem_* / i_mem_*        : external req/ack memory interface
// mem_req is raised the cycle after the op pulse with address/data/we already
// registered, held until ack, and dropped the cycle after ack. An ack while no
// request is outstanding is ignored.
module rc4_mem_port #(
    parameter int SW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_op,
    input  logic [SW-1:0] i_addr,
    input  logic [SW-1:0] i_wdata,
    input  logic          i_we,
    output logic          o_rdone,
    output logic [SW-1:0] o_rdata,
    output logic [SW-1:0] o_mem_addr,
    output logic [SW-1:0] o_mem_wdata,
    output logic          o_mem_we,
    output logic          o_mem_req,
    input  logic          i_mem_ack,
    input  logic [SW-1:0] i_mem_rdata
);

    logic          r_req;
    logic          r_rdone;
    logic [SW-1:0] r_rdata;
    logic [SW-1:0] r_addr;
    logic [SW-1:0] r_wdata;
    logic          r_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_req   <= 1'b0;
            r_rdone <= 1'b0;
            r_rdata <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
        end else begin
            r_rdone <= 1'b0;
            if (r_req) begin
                if (i_mem_ack) begin
                    r_req   <= 1'b0;
                    r_rdone <= 1'b1;
                    r_rdata <= i_mem_rdata;
                end
            end else if (i_op) begin
                r_req   <= 1'b1;
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
                r_we    <= i_we;
            end
        end
    end

    assign o_rdone     = r_rdone;
    assign o_rdata     = r_rdata;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_mem_we    = r_we;
    assign o_mem_req   = r_req;

endmodule

// File: rtl/rc4_sched_gen.sv
// rc4_sched_gen: RC4 key-scheduling (KSA) swap loop over an external S RAM,
// optionally followed by PRGA keystream generation on a valid/ready stream.
//   clk, reset           : clock, synchronous active-high reset
//   start, mode, msg_len : run request (mode/msg_len latched at start in IDLE)
//   secret_key           : key, byte 0 in the most significant byte
//   busy, done           : status; done pulses for one cycle at completion
//   mem_*                : req/ack port to the single-port S RAM
//   ks_data/valid/ready  : keystream output stream
// Every RAM access state issues one op on entry and waits for rdone, so with a
// one-cycle ack a KSA iteration takes KSA_CYCLES_PER_ITER (18) cycles.
module rc4_sched_gen
    import rc4_pkg::*;
#(
    parameter int SW        = 8,
    parameter int KEY_BYTES = 3,
    parameter int LEN_W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [LEN_W-1:0]       msg_len,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    output logic                   busy,
    output logic                   done,
    output logic [SW-1:0]          mem_addr,
    output logic [SW-1:0]          mem_wdata,
    output logic                   mem_we,
    output logic                   mem_req,
    input  logic                   mem_ack,
    input  logic [SW-1:0]          mem_rdata,
    output logic [SW-1:0]          ks_data,
    output logic                   ks_valid,
    input  logic                   ks_ready
);

    localparam int                KIDX_W    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);
    localparam logic [SW-1:0]     I_LAST    = '1;

    rc4_state_t        r_state, w_state_next;
    logic [1:0]        r_mode, w_mode_next;
    logic [LEN_W-1:0]  r_len, w_len_next;
    logic [LEN_W-1:0]  r_cnt, w_cnt_next;
    logic [SW-1:0]     r_i, w_i_next;
    logic [SW-1:0]     r_j, w_j_next;
    logic [SW-1:0]     r_si, w_si_next;
    logic [SW-1:0]     r_sj, w_sj_next;
    logic [SW-1:0]     r_ks, w_ks_next;
    logic [KIDX_W-1:0] r_kidx, w_kidx_next;
    logic              r_issued, w_issued_next;

    logic              w_op;
    logic              w_op_we;
    logic [SW-1:0]     w_op_addr;
    logic [SW-1:0]     w_op_wdata;
    logic              w_rdone;
    logic [SW-1:0]     w_rdata;
    logic [SW-1:0]     w_key_sw;
    logic [LEN_W-1:0]  w_cnt_inc;

    // Split the key into bytes; byte 0 sits in the top bits.
    logic [7:0] w_key_bytes [KEY_BYTES];
    for (genvar gi = 0; gi < KEY_BYTES; gi++) begin : g_key
        assign w_key_bytes[gi] = secret_key[8*(KEY_BYTES-gi)-1 -: 8];
    end

    assign w_key_sw  = SW'(w_key_bytes[r_kidx]);
    assign w_cnt_inc = r_cnt + LEN_W'(1);

    rc4_mem_port #(.SW(SW)) u_mem_port (
        .clk         (clk),
        .reset       (reset),
        .i_op        (w_op),
        .i_addr      (w_op_addr),
        .i_wdata     (w_op_wdata),
        .i_we        (w_op_we),
        .o_rdone     (w_rdone),
        .o_rdata     (w_rdata),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_we    (mem_we),
        .o_mem_req   (mem_req),
        .i_mem_ack   (mem_ack),
        .i_mem_rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_mode   <= MODE_KSA;
            r_len    <= '0;
            r_cnt    <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_si     <= '0;
            r_sj     <= '0;
            r_ks     <= '0;
            r_kidx   <= '0;
            r_issued <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_mode   <= w_mode_next;
            r_len    <= w_len_next;
            r_cnt    <= w_cnt_next;
            r_i      <= w_i_next;
            r_j      <= w_j_next;
            r_si     <= w_si_next;
            r_sj     <= w_sj_next;
            r_ks     <= w_ks_next;
            r_kidx   <= w_kidx_next;
            r_issued <= w_issued_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_mode_next   = r_mode;
        w_len_next    = r_len;
        w_cnt_next    = r_cnt;
        w_i_next      = r_i;
        w_j_next      = r_j;
        w_si_next     = r_si;
        w_sj_next     = r_sj;
        w_ks_next     = r_ks;
        w_kidx_next   = r_kidx;
        w_issued_next = r_issued;
        w_op          = 1'b0;
        w_op_we       = 1'b0;
        w_op_addr     = '0;
        w_op_wdata    = '0;

        // One op per memory state: fire on the first cycle, then wait for rdone.
        if (is_mem_state(r_state)) begin
            w_op = !r_issued;
            if (w_op)    w_issued_next = 1'b1;
            if (w_rdone) w_issued_next = 1'b0;
        end

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_i_next    = '0;
                    w_j_next    = '0;
                    w_kidx_next = '0;
                    w_len_next  = msg_len;
                    w_mode_next = (mode == MODE_PRGA || mode == MODE_BOTH) ? mode : MODE_KSA;
                    w_state_next = (mode == MODE_PRGA) ? ST_PRGA_INIT : ST_KSA_RD_I;
                end
            end
            ST_KSA_RD_I: begin
                w_op_addr = r_i;
                if (w_rdone) begin
                    w_si_next    = w_rdata;
                    w_state_next = ST_KSA_CALC;
                end
            end
            ST_KSA_CALC: begin
                w_j_next     = r_j + r_si + w_key_sw;
                w_state_next = ST_KSA_RD_J;
            end
            ST_KSA_RD_J: begin
                w_op_addr = r_j;
                if (w_rdone) begin
                    w_sj_next    = w_rdata;
                    w_state_next = ST_KSA_WR_I;
                end
            end
            ST_KSA_WR_I: begin
                w_op_addr  = r_i;
                w_op_wdata = r_sj;
                w_op_we    = 1'b1;
                if (w_rdone) w_state_next = ST_KSA_WR_J;
            end
            ST_KSA_WR_J: begin
                w_op_addr  = r_j;
                w_op_wdata = r_si;
                w_op_we    = 1'b1;
                if (w_rdone) w_state_next = ST_KSA_NEXT;
            end
            ST_KSA_NEXT: begin
                if (r_i == I_LAST) begin
                    w_state_next = (r_mode == MODE_BOTH) ? ST_PRGA_INIT : ST_DONE;
                end else begin
                    w_i_next     = r_i + SW'(1);
                    w_kidx_next  = (r_kidx == KIDX_LAST) ? '0 : r_kidx + KIDX_W'(1);
                    w_state_next = ST_KSA_RD_I;
                end
            end
            ST_PRGA_INIT: begin
                w_i_next     = '0;
                w_j_next     = '0;
                w_cnt_next   = '0;
                w_state_next = (r_len == '0) ? ST_DONE : ST_PRGA_INC;
            end
            ST_PRGA_INC: begin
                w_i_next     = r_i + SW'(1);
                w_state_next = ST_PRGA_RD_I;
            end
            ST_PRGA_RD_I: begin
                w_op_addr = r_i;
                if (w_rdone) begin
                    w_si_next    = w_rdata;
                    w_state_next = ST_PRGA_CALC;
                end
            end
            ST_PRGA_CALC: begin
                w_j_next     = r_j + r_si;
                w_state_next = ST_PRGA_RD_J;
            end
            ST_PRGA_RD_J: begin
                w_op_addr = r_j;
                if (w_rdone) begin
                    w_sj_next    = w_rdata;
                    w_state_next = ST_PRGA_WR_I;
                end
            end
            ST_PRGA_WR_I: begin
                w_op_addr  = r_i;
                w_op_wdata = r_sj;
                w_op_we    = 1'b1;
                if (w_rdone) w_state_next = ST_PRGA_WR_J;
            end
            ST_PRGA_WR_J: begin
                w_op_addr  = r_j;
                w_op_wdata = r_si;
                w_op_we    = 1'b1;
                if (w_rdone) w_state_next = ST_PRGA_RD_T;
            end
            ST_PRGA_RD_T: begin
                // si/sj still hold the pre-swap values, which is what RC4 sums.
                w_op_addr = r_si + r_sj;
                if (w_rdone) begin
                    w_ks_next    = w_rdata;
                    w_state_next = ST_PRGA_OUT;
                end
            end
            ST_PRGA_OUT: begin
                if (ks_ready) begin
                    w_cnt_next   = w_cnt_inc;
                    w_state_next = (w_cnt_inc == r_len) ? ST_DONE : ST_PRGA_INC;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign busy     = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done     = (r_state == ST_DONE);
    assign ks_valid = (r_state == ST_PRGA_OUT);
    assign ks_data  = r_ks;

endmodule

// File: tb/tb_rc4_sched_gen.sv
// Directed testbench for rc4_sched_gen: behavioural S RAM with configurable
// ack delay, a negedge stream/handshake monitor, and scenario tasks.
module tb_rc4_sched_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        start5 = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  msg_len = 8'd0;
    logic [23:0] secret_key = 24'h4B6579;
    logic [39:0] secret_key5 = 40'h0102030405;
    logic        ks_ready = 1'b1;

    logic        busy, done, mem_we, mem_req, ks_valid;
    logic [7:0]  mem_addr, mem_wdata, ks_data;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'd0;

    logic        busy5, done5, mem_we5, mem_req5, ks_valid5;
    logic [7:0]  mem_addr5, mem_wdata5, ks_data5;
    logic        mem_ack5 = 1'b0;
    logic [7:0]  mem_rdata5 = 8'd0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rc4_sched_gen #(.SW(8), .KEY_BYTES(3), .LEN_W(8)) u_dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .msg_len(msg_len),
        .secret_key(secret_key), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_req(mem_req),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready)
    );

    rc4_sched_gen #(.SW(8), .KEY_BYTES(5), .LEN_W(8)) u_dut5 (
        .clk(clk), .reset(reset), .start(start5), .mode(mode), .msg_len(msg_len),
        .secret_key(secret_key5), .busy(busy5), .done(done5),
        .mem_addr(mem_addr5), .mem_wdata(mem_wdata5), .mem_we(mem_we5), .mem_req(mem_req5),
        .mem_ack(mem_ack5), .mem_rdata(mem_rdata5),
        .ks_data(ks_data5), .ks_valid(ks_valid5), .ks_ready(ks_ready)
    );

    // ---------------- behavioural S RAMs ----------------
    logic [7:0] s_mem  [256];
    logic [7:0] s_mem5 [256];
    logic       init_req = 1'b0;
    int         ack_delay_max = 0;   // >1: ack 1..ack_delay_max cycles after req
    int         wait_cnt = 0;
    int         op_count = 0;

    always @(posedge clk) begin
        if (init_req) for (int k = 0; k < 256; k++) s_mem[k] <= 8'(k);
        if (mem_ack) begin
            mem_ack <= 1'b0;
        end else if (mem_req) begin
            if (wait_cnt == 0) begin
                mem_ack   <= 1'b1;
                mem_rdata <= s_mem[mem_addr];
                if (mem_we) s_mem[mem_addr] <= mem_wdata;
                op_count  <= op_count + 1;
                wait_cnt  <= (ack_delay_max > 1) ? int'($urandom_range(ack_delay_max - 1, 0)) : 0;
            end else begin
                wait_cnt <= wait_cnt - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (init_req) for (int k = 0; k < 256; k++) s_mem5[k] <= 8'(k);
        if (mem_ack5) begin
            mem_ack5 <= 1'b0;
        end else if (mem_req5) begin
            mem_ack5   <= 1'b1;
            mem_rdata5 <= s_mem5[mem_addr5];
            if (mem_we5) s_mem5[mem_addr5] <= mem_wdata5;
        end
    end

    // ---------------- consumer ready driver ----------------
    bit rand_ready = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            ks_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
        end
    end

    // ---------------- negedge monitor ----------------
    logic [7:0] ks_q[$];
    logic [7:0] ks5_q[$];
    int ks_viol = 0, mem_viol = 0, valid_cyc = 0, done_cyc = 0, busy_cyc = 0;
    logic       p_valid = 0, p_ready = 0, p_req = 0, p_ack = 0, p_we = 0, p_rst = 1;
    logic [7:0] p_ks = 0, p_addr = 0, p_wd = 0;

    always @(negedge clk) begin
        if (ks_valid && ks_ready) ks_q.push_back(ks_data);
        if (ks_valid5 && ks_ready) ks5_q.push_back(ks_data5);
        if (!reset && !p_rst && p_valid && !p_ready && (!ks_valid || ks_data != p_ks))
            ks_viol++;
        if (!reset && !p_rst && p_req && !p_ack &&
            (!mem_req || mem_addr != p_addr || mem_we != p_we || mem_wdata != p_wd))
            mem_viol++;
        if (ks_valid) valid_cyc++;
        if (done)     done_cyc++;
        if (busy)     busy_cyc++;
        p_valid = ks_valid; p_ready = ks_ready; p_ks = ks_data;
        p_req = mem_req; p_ack = mem_ack; p_addr = mem_addr; p_we = mem_we; p_wd = mem_wdata;
        p_rst = reset;
    end

    // ---------------- software reference ----------------
    logic [7:0] m_s[256];
    logic [7:0] m_ks[$];

    function automatic void model_init();
        for (int k = 0; k < 256; k++) m_s[k] = 8'(k);
    endfunction

    function automatic void model_ksa(input logic [39:0] key, input int nb);
        logic [7:0] j, t, kb;
        j = 8'd0;
        for (int i = 0; i < 256; i++) begin
            kb = key[8*(nb - (i % nb)) - 1 -: 8];
            j = j + m_s[i] + kb;
            t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
        end
    endfunction

    function automatic void model_prga(input int n);
        logic [7:0] i, j, t, ti;
        i = 8'd0; j = 8'd0;
        m_ks.delete();
        for (int c = 0; c < n; c++) begin
            i = i + 8'd1;
            j = j + m_s[i];
            t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
            ti = m_s[i] + m_s[j];
            m_ks.push_back(m_s[ti]);
        end
    endfunction

    logic [7:0] exp_key [9] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7};
    logic [7:0] exp_k5  [8] = '{8'hB2, 8'h39, 8'h63, 8'h05, 8'hF0, 8'h3D, 8'hC0, 8'h27};

    // ---------------- stimulus helpers ----------------
    task automatic init_ram();
        @(negedge clk); init_req = 1'b1;
        @(negedge clk); init_req = 1'b0;
    endtask

    task automatic do_start(input bit use5, input logic [1:0] m, input logic [7:0] len);
        @(negedge clk);
        mode = m; msg_len = len;
        if (use5) start5 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0; start5 = 1'b0;
    endtask

    task automatic wait_done(input bit use5, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 30000; c++) begin
            @(negedge clk);
            if ((use5 ? done5 : done) === 1'b1) begin ok = 1'b1; break; end
        end
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [39:0] outs;
        repeat (3) @(negedge clk);
        outs = {busy, done, mem_req, mem_we, ks_valid, mem_addr, mem_wdata, ks_data, 3'b000};
        n_checks++;
        if (outs !== 40'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %010h expected 0", outs);
        end
        reset = 1'b0;
        $display("test_reset: outputs=%010h", outs);
    endtask

    task automatic test_ksa_prga(input bit toggle);
        bit ok; int d0, v0;
        rand_ready = toggle;
        init_ram();
        ks_q.delete();
        d0 = done_cyc; v0 = ks_viol;
        do_start(1'b0, 2'd2, 8'd9);
        wait_done(1'b0, ok);
        rand_ready = 1'b0;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL ksa_prga_timeout: done got 0 expected 1"); end
        n_checks++;
        if (ks_q.size() != 9) begin
            n_fail++; $display("FAIL ksa_prga_count: got %0d expected 9", ks_q.size());
        end
        for (int k = 0; k < 9 && k < ks_q.size(); k++) begin
            n_checks++;
            if (ks_q[k] !== exp_key[k]) begin
                n_fail++; $display("FAIL ks_byte[%0d]: got %02h expected %02h", k, ks_q[k], exp_key[k]);
            end
        end
        n_checks++;
        if (done_cyc - d0 != 1) begin
            n_fail++; $display("FAIL done_pulse: got %0d cycles expected 1", done_cyc - d0);
        end
        n_checks++;
        if (ks_viol - v0 != 0) begin
            n_fail++; $display("FAIL ks_stable: got %0d violations expected 0", ks_viol - v0);
        end
        $display("test_ksa_prga toggle=%0d: %0d bytes, first=%02h", toggle, ks_q.size(),
                 ks_q.size() > 0 ? ks_q[0] : 8'h00);
    endtask

    task automatic test_ksa_only(input int delay, input logic [1:0] m);
        bit ok; int o0, v0, b0, mv0, bad;
        ack_delay_max = delay;
        init_ram();
        o0 = op_count; v0 = valid_cyc; b0 = busy_cyc; mv0 = mem_viol;
        do_start(1'b0, m, 8'd5);
        wait_done(1'b0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL ksa_timeout: done got 0 expected 1"); end
        model_init(); model_ksa({16'h0, secret_key}, 3);
        bad = -1;
        for (int k = 255; k >= 0; k--) if (s_mem[k] !== m_s[k]) bad = k;
        n_checks++;
        if (bad >= 0) begin
            n_fail++; $display("FAIL ksa_ram[%0d]: got %02h expected %02h", bad, s_mem[bad], m_s[bad]);
        end
        n_checks++;
        if (op_count - o0 != 1024) begin
            n_fail++; $display("FAIL ksa_op_count: got %0d expected 1024", op_count - o0);
        end
        n_checks++;
        if (valid_cyc - v0 != 0) begin
            n_fail++; $display("FAIL ksa_no_valid: got %0d valid cycles expected 0", valid_cyc - v0);
        end
        n_checks++;
        if (mem_viol - mv0 != 0) begin
            n_fail++; $display("FAIL mem_stable: got %0d violations expected 0", mem_viol - mv0);
        end
        if (delay <= 1) begin
            n_checks++;
            if (busy_cyc - b0 != 256 * 18) begin
                n_fail++; $display("FAIL ksa_latency: got %0d busy cycles expected %0d", busy_cyc - b0, 256 * 18);
            end
        end
        ack_delay_max = 0;
        $display("test_ksa_only delay=%0d mode=%0d: ops=%0d busy=%0d", delay, m, op_count - o0, busy_cyc - b0);
    endtask

    task automatic test_len_zero_then_prga();
        bit ok; int v0, d0;
        init_ram();
        ks_q.delete();
        v0 = valid_cyc; d0 = done_cyc;
        do_start(1'b0, 2'd2, 8'd0);
        wait_done(1'b0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL len0_timeout: done got 0 expected 1"); end
        n_checks++;
        if (valid_cyc - v0 != 0 || done_cyc - d0 != 1) begin
            n_fail++; $display("FAIL len0_stream: got valid=%0d done=%0d expected valid=0 done=1",
                               valid_cyc - v0, done_cyc - d0);
        end
        do_start(1'b0, 2'd1, 8'd3);
        wait_done(1'b0, ok);
        n_checks++;
        if (!ok || ks_q.size() != 3) begin
            n_fail++; $display("FAIL prga_only_count: got %0d bytes expected 3", ks_q.size());
        end
        for (int k = 0; k < 3 && k < ks_q.size(); k++) begin
            n_checks++;
            if (ks_q[k] !== exp_key[k]) begin
                n_fail++; $display("FAIL prga_only_byte[%0d]: got %02h expected %02h", k, ks_q[k], exp_key[k]);
            end
        end
        $display("test_len_zero_then_prga: %0d bytes", ks_q.size());
    endtask

    task automatic test_reset_mid();
        bit ok; int o0; logic [39:0] outs;
        init_ram();
        o0 = op_count;
        do_start(1'b0, 2'd2, 8'd9);
        ok = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (op_count - o0 >= 401) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL reset_mid_reach: got %0d ops expected 401", op_count - o0); end
        reset = 1'b1;
        @(negedge clk);
        outs = {busy, done, mem_req, mem_we, ks_valid, mem_addr, mem_wdata, ks_data, 3'b000};
        n_checks++;
        if (outs !== 40'd0) begin
            n_fail++; $display("FAIL reset_mid_outputs: got %010h expected 0", outs);
        end
        reset = 1'b0;
        $display("test_reset_mid: outputs after reset=%010h", outs);
        test_ksa_prga(1'b0);
    endtask

    task automatic test_key5();
        bit ok; int bad;
        init_ram();
        ks5_q.delete();
        do_start(1'b1, 2'd2, 8'd8);
        wait_done(1'b1, ok);
        n_checks++;
        if (!ok || ks5_q.size() != 8) begin
            n_fail++; $display("FAIL key5_count: got %0d bytes expected 8", ks5_q.size());
        end
        for (int k = 0; k < 8 && k < ks5_q.size(); k++) begin
            n_checks++;
            if (ks5_q[k] !== exp_k5[k]) begin
                n_fail++; $display("FAIL key5_byte[%0d]: got %02h expected %02h", k, ks5_q[k], exp_k5[k]);
            end
        end
        model_init(); model_ksa(secret_key5, 5); model_prga(8);
        bad = -1;
        for (int k = 255; k >= 0; k--) if (s_mem5[k] !== m_s[k]) bad = k;
        n_checks++;
        if (bad >= 0) begin
            n_fail++; $display("FAIL key5_ram[%0d]: got %02h expected %02h", bad, s_mem5[bad], m_s[bad]);
        end
        $display("test_key5: %0d bytes", ks5_q.size());
    endtask

    initial begin
        test_reset();
        test_ksa_prga(1'b0);
        test_ksa_prga(1'b1);
        test_ksa_only(0, 2'd0);
        test_ksa_only(0, 2'd3);
        test_ksa_only(7, 2'd0);
        test_len_zero_then_prga();
        test_reset_mid();
        test_key5();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
